// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - iterative radix-2 restoring divider with stall/sequencing FSM
//
// Purpose: executes DIV/DIVU from the master-pipe E stage, one quotient bit per
// cycle, holding the pipeline via E_div_stall until quotient/remainder are ready.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   E_div_en     E-stage instruction is a valid DIV/DIVU
//   E_div_signed 1 = signed divide
//   E_src_a      dividend
//   E_src_b      divisor
//   E_cancel     abort the E-stage instruction (flush/exception)
//   E_hold       E stage held by another stall source
//   E_div_stall  combinational stall request to the hazard unit
//   div_done     results valid this cycle
//   div_lo       quotient
//   div_hi       remainder

module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             E_div_en,
   input  logic             E_div_signed,
   input  logic [WIDTH-1:0] E_src_a,
   input  logic [WIDTH-1:0] E_src_b,
   input  logic             E_cancel,
   input  logic             E_hold,
   output logic             E_div_stall,
   output logic             div_done,
   output logic [WIDTH-1:0] div_lo,
   output logic [WIDTH-1:0] div_hi
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] quo_q;        // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] rem_q;        // partial remainder
   logic [WIDTH-1:0] dvs_q;        // |divisor|
   logic [CW-1:0]    cnt_q;
   logic             signed_q;
   logic             sign_a_q;
   logic             sign_diff_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] hi_q;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;
   logic             last_iter;

   always_comb begin
      a_neg = E_div_signed & E_src_a[WIDTH-1];
      b_neg = E_div_signed & E_src_b[WIDTH-1];
      a_abs = a_neg ? -E_src_a : E_src_a;
      b_abs = b_neg ? -E_src_b : E_src_b;

      // Shifted remainder needs WIDTH+1 bits for the trial subtract; a negative
      // result (MSB set) means the divisor did not fit this step.
      trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
      rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

      // Negation wraps, so the most-negative / -1 case yields the most-negative value.
      q_fix = (signed_q & sign_diff_q) ? -quo_d : quo_d;
      r_fix = (signed_q & sign_a_q)    ? -rem_d : rem_d;

      last_iter = (cnt_q == CW'(WIDTH - 1));
   end

   assign E_div_stall = ~E_cancel & (((state_q == IDLE) & E_div_en) | (state_q == BUSY));
   assign div_done    = (state_q == DONE);
   assign div_lo      = lo_q;
   assign div_hi      = hi_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         signed_q    <= 1'b0;
         sign_a_q    <= 1'b0;
         sign_diff_q <= 1'b0;
         lo_q        <= '0;
         hi_q        <= '0;
      end else if (E_cancel) begin
         // Partial state is discarded; last delivered results stay visible.
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (E_div_en) begin
                  quo_q       <= a_abs;
                  dvs_q       <= b_abs;
                  rem_q       <= '0;
                  cnt_q       <= '0;
                  signed_q    <= E_div_signed;
                  sign_a_q    <= a_neg;
                  sign_diff_q <= a_neg ^ b_neg;
                  if (E_src_b == '0) begin
                     lo_q    <= '1;
                     hi_q    <= E_src_a;
                     state_q <= DONE;
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               quo_q <= quo_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q + 1'b1;
               if (last_iter) begin
                  lo_q    <= q_fix;
                  hi_q    <= r_fix;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (!E_hold) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - self-checking bench for div_sequencer

module tb_div_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         E_div_en;
   logic         E_div_signed;
   logic [W-1:0] E_src_a;
   logic [W-1:0] E_src_b;
   logic         E_cancel;
   logic         E_hold;
   logic         E_div_stall;
   logic         div_done;
   logic [W-1:0] div_lo;
   logic [W-1:0] div_hi;

   int vectors = 0;
   int miscompares = 0;

   div_sequencer #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .E_div_en     (E_div_en),
      .E_div_signed (E_div_signed),
      .E_src_a      (E_src_a),
      .E_src_b      (E_src_b),
      .E_cancel     (E_cancel),
      .E_hold       (E_hold),
      .E_div_stall  (E_div_stall),
      .div_done     (div_done),
      .div_lo       (div_lo),
      .div_hi       (div_hi)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           sgn;
      int           hold;
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_r;
      int           exp_stall;
   } vec_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic in 64 bits, truncated back to W.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      longint sa, sb;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = W'(sa / sb);
         r = W'(sa % sb);
      end
   endfunction

   // Runs one divide starting in IDLE at the next negedge; holds DONE for `hold` extra cycles.
   task automatic do_div(input vec_t v);
      int stalls;
      bit ok;
      @(negedge clk);
      E_div_en = 1'b1; E_div_signed = v.sgn; E_src_a = v.a; E_src_b = v.b;
      E_cancel = 1'b0; E_hold = 1'b0;
      stalls = 0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (E_div_stall) begin
            stalls++;
            @(negedge clk);
         end else begin
            ok = 1'b1;
            break;
         end
      end
      chk("stall_bound", W'(ok), W'(1));
      chk("stall_cycles", W'(stalls), W'(v.exp_stall));
      E_div_en = 1'b0;
      for (int k = 0; k <= v.hold; k++) begin
         if (k > 0) @(negedge clk);
         E_hold = (k < v.hold);
         #1;
         chk("done", W'(div_done), W'(1));
         chk("done_stall", W'(E_div_stall), W'(0));
         chk("q", div_lo, v.exp_q);
         chk("r", div_hi, v.exp_r);
      end
      @(negedge clk);
      E_hold = 1'b0;
      #1;
      chk("done_drop", W'(div_done), W'(0));
   endtask

   vec_t tbl[$];
   vec_t v;
   logic [W-1:0] pq, pr;

   initial begin
      rst = 1'b1; E_div_en = 1'b0; E_div_signed = 1'b0; E_src_a = '0; E_src_b = '0;
      E_cancel = 1'b0; E_hold = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_lo", div_lo, '0);
      chk("rst_hi", div_hi, '0);
      chk("rst_done", W'(div_done), W'(0));
      chk("rst_stall", W'(E_div_stall), W'(0));
      @(negedge clk);
      rst = 1'b0;

      tbl.push_back('{32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 33});
      tbl.push_back('{32'hFFFFFFF9, 32'd2, 1'b1, 0, 32'hFFFFFFFD, 32'hFFFFFFFF, 33});
      tbl.push_back('{32'd7, 32'hFFFFFFFE, 1'b1, 0, 32'hFFFFFFFD, 32'd1, 33});
      tbl.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 32'h80000000, 32'd0, 33});
      tbl.push_back('{32'd5, 32'd0, 1'b0, 0, 32'hFFFFFFFF, 32'd5, 1});
      tbl.push_back('{32'hFFFFFFF9, 32'd0, 1'b1, 0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1});
      tbl.push_back('{32'hFFFFFFFF, 32'd1, 1'b0, 0, 32'hFFFFFFFF, 32'd0, 33});
      tbl.push_back('{32'd100, 32'd7, 1'b0, 3, 32'd14, 32'd2, 33});
      tbl.push_back('{32'd200, 32'd9, 1'b0, 0, 32'd22, 32'd2, 33});
      foreach (tbl[i]) do_div(tbl[i]);

      // Cancel at BUSY cycle 10: prior results (22/2) must survive.
      @(negedge clk);
      E_div_en = 1'b1; E_div_signed = 1'b0; E_src_a = 32'd100; E_src_b = 32'd7;
      repeat (10) @(negedge clk);
      E_cancel = 1'b1;
      #1;
      chk("cancel_stall", W'(E_div_stall), W'(0));
      @(negedge clk);
      E_cancel = 1'b0; E_div_en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (div_done || E_div_stall) begin
            chk("cancel_quiet", W'({div_done, E_div_stall}), W'(0));
            break;
         end
         @(negedge clk);
      end
      chk("cancel_lo", div_lo, 32'd22);
      chk("cancel_hi", div_hi, 32'd2);
      v = '{32'd9, 32'd3, 1'b0, 0, 32'd3, 32'd0, 33};
      do_div(v);

      // Reset in the middle of BUSY.
      @(negedge clk);
      E_div_en = 1'b1; E_div_signed = 1'b0; E_src_a = 32'd1000; E_src_b = 32'd3;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; E_div_en = 1'b0;
      #1;
      chk("mid_rst_lo", div_lo, '0);
      chk("mid_rst_hi", div_hi, '0);
      chk("mid_rst_done", W'(div_done), W'(0));
      chk("mid_rst_stall", W'(E_div_stall), W'(0));

      // Randomized divides against the arithmetic model.
      for (int n = 0; n < 24; n++) begin
         v.a = $urandom;
         case ($urandom_range(0, 3))
            0: v.b = 32'd0;
            1: v.b = $urandom_range(1, 20);
            2: v.b = -($urandom_range(1, 20));
            default: v.b = $urandom;
         endcase
         v.sgn = $urandom_range(0, 1);
         v.hold = $urandom_range(0, 2);
         model(v.a, v.b, v.sgn, pq, pr);
         v.exp_q = pq;
         v.exp_r = pr;
         v.exp_stall = (v.b == 0) ? 1 : W + 1;
         do_div(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iterative radix-2 restoring divider plus its control FSM, placed in the execute stage of the dual-issue pipeline.
- Accepts a DIV/DIVU from the master pipe's E stage and sequences one quotient bit per cycle.
- Drives E_div_stall to the hazard unit, which freezes F/D/E/M/W while the divide runs.
- Delivers quotient (LO) and remainder (HI) in the cycle the stall drops.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-high reset
E_div_en  in  1  master-pipe E-stage instruction is DIV/DIVU and valid
E_div_signed  in  1  1 = DIV (signed), 0 = DIVU
E_src_a  in  WIDTH  dividend
E_src_b  in  WIDTH  divisor
E_cancel  in  1  abort: branch flush or exception on the E instruction
E_hold  in  1  E stage held by a stall source other than the divider
E_div_stall  out  1  combinational stall request to the hazard unit
div_done  out  1  results valid this cycle
div_lo  out  WIDTH  quotient
div_hi  out  WIDTH  remainder

Behaviour:
- Reset: state=IDLE, all datapath registers cleared. div_lo=0, div_hi=0, div_done=0, E_div_stall=0. Reset overrides every other input, including mid-operation; no result is produced for an aborted divide.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If E_div_en & ~E_cancel: E_div_stall=1 this cycle (cycle T).
  - At the edge, latch |a|, |b|, the signed flag, sign(a) and sign(a)^sign(b); clear the partial remainder.
  - Next state: BUSY, or DONE if E_src_b==0.
  - Otherwise stay in IDLE with stall=0.
- BUSY:
  - Stall=1.
  - Each cycle: shift {rem,quo} left by 1; trial-subtract |b| from rem; if non-negative, keep the difference and set the quotient LSB to 1.
  - An iteration counter runs 0..WIDTH-1.
  - On the final iteration edge, register the sign-corrected results and go to DONE.
- Sign correction (signed only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - Negation wraps in WIDTH bits, so 0x80000000 / -1 gives q=0x80000000, r=0.
  - Unsigned divides apply no correction.
- Divide by zero: q = all ones, r = dividend (raw, uncorrected). Goes IDLE->DONE directly, so stall lasts 1 cycle.
- DONE:
  - Stall=0, div_done=1; div_lo/div_hi hold the results.
  - If E_hold=1, remain in DONE; outputs stay stable and stall stays 0.
  - If E_hold=0, go to IDLE. The pipeline advances at the same edge.
  - A new div arriving in the following cycle restarts normally (back-to-back supported).
- Latency for a normal divide:
  - E_div_stall is high for WIDTH+1 cycles (T through T+WIDTH).
  - DONE at T+WIDTH+1.
- E_div_stall = ~E_cancel & ((IDLE & E_div_en) | BUSY).
- E_cancel:
  - Takes effect in any state.
  - Stall drops in the same cycle.
  - Next state is IDLE; the partial result is discarded and div_done does not pulse.
  - E_cancel together with E_div_en in IDLE: the divide is not accepted.
- div_lo/div_hi change only on the edge into DONE. Between divides they hold the last result.

Test Plan:
- Unsigned, a=100, b=7 -> stall high exactly 33 cycles; DONE with div_lo=14, div_hi=2, div_done high 1 cycle.
- Signed, a=-7 (0xFFFFFFF9), b=2 -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF. Also a=7, b=-2 -> div_lo=0xFFFFFFFD, div_hi=1.
- Edge cases:
  - Signed 0x80000000 / 0xFFFFFFFF -> div_lo=0x80000000, div_hi=0.
  - Unsigned 5/0 -> stall 1 cycle, div_lo=0xFFFFFFFF, div_hi=5.
- Cancel: start 100/7, assert E_cancel at BUSY cycle 10 -> stall 0 that cycle, IDLE next, no div_done, prior div_lo/div_hi unchanged. Then a fresh 9/3 completes with q=3, r=0.
- Hold and back-to-back: 100/7 completes with E_hold=1 for 3 DONE cycles -> div_done high 4 cycles, stall 0, outputs stable. Then release, and 200/9 presented the next cycle -> q=22, r=2 after 33 stall cycles.
- Reset mid-op: rst asserted at BUSY cycle 20 -> next cycle IDLE with div_lo=div_hi=0, stall=0, div_done=0.
